cdb_rr_arb: RTL

Parametrised common-data-bus arbiter for the execute stage. Merges write-back requests from CH execution units (ALU, divider, FPU, FP divider, CSR, memory, and any future units) onto the single result bus. Grants one winner per cycle under fixed-priority or round-robin policy, and announces the winner's destination tag one cycle before its data is broadcast so the issue stage can wake up dependants early. Sits between the execution units and the issue/ROB write-back ports.

---
 rtl/cdb_rr_arb.sv | 109 ++++++++++
 1 files changed

// File: rtl/cdb_rr_arb.sv
// Common-data-bus arbiter: picks one execution-unit write-back per cycle, announces its tag
// combinationally and broadcasts the full result from registers one cycle later.
module cdb_rr_arb #(
   parameter int CH   = 6,
   parameter int DATA = 32,
   parameter int RD   = 8,
   parameter int EXP  = 4,
   parameter int RR   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_,
   input  logic [CH-1:0]       ch_wb_req_,
   output logic [CH-1:0]       ch_wb_ack_,
   input  logic [CH*RD-1:0]    ch_pre_wb_rd,
   input  logic [CH*DATA-1:0]  ch_wb_data,
   input  logic [CH-1:0]       ch_wb_exp_,
   input  logic [CH*EXP-1:0]   ch_wb_exp_code,
   output logic                conflict_,
   output logic                pre_wb_e_,
   output logic [RD-1:0]       pre_wb_rd,
   output logic                wb_e_,
   output logic [RD-1:0]       wb_rd,
   output logic [DATA-1:0]     wb_data,
   output logic                wb_exp_,
   output logic [EXP-1:0]      wb_exp_code
);

   localparam int PW = (CH > 1) ? $clog2(CH) : 1;

   logic [PW-1:0]   ptr_reg;
   logic [PW-1:0]   win;
   logic            grant_vld;
   logic [CH-1:0]   req_raw;
   logic [CH-1:0]   req_act;
   logic            wb_e_reg;
   logic [RD-1:0]   wb_rd_reg;
   logic [DATA-1:0] wb_data_reg;
   logic            wb_exp_reg;
   logic [EXP-1:0]  wb_exp_code_reg;

   logic [RD-1:0]   rd_arr   [CH];
   logic [DATA-1:0] data_arr [CH];
   logic [EXP-1:0]  code_arr [CH];

   assign req_raw = ~ch_wb_req_;
   // Flush and reset suppress grants but not the contention indication.
   assign req_act = req_raw & {CH{flush_ & ~reset}};

   // Two or more requests pending <=> clearing the lowest set bit leaves something set.
   assign conflict_ = ~|(req_raw & (req_raw - 1'b1));

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         assign rd_arr[gi]     = ch_pre_wb_rd[gi*RD +: RD];
         assign data_arr[gi]   = ch_wb_data[gi*DATA +: DATA];
         assign code_arr[gi]   = ch_wb_exp_code[gi*EXP +: EXP];
         assign ch_wb_ack_[gi] = ~(grant_vld && (win == PW'(gi)));
      end
   endgenerate

   // Search order starts at ptr for round-robin, at channel 0 for fixed priority.
   always_comb begin
      int idx;
      grant_vld = 1'b0;
      win       = '0;
      idx       = 0;
      for (int i = 0; i < CH; i++) begin
         idx = (RR != 0) ? int'(ptr_reg) + i : i;
         if (idx >= CH)
            idx = idx - CH;
         if (!grant_vld && req_act[idx]) begin
            grant_vld = 1'b1;
            win       = PW'(idx);
         end
      end
   end

   assign pre_wb_e_ = ~grant_vld;
   assign pre_wb_rd = grant_vld ? rd_arr[win] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_reg         <= '0;
         wb_e_reg        <= 1'b1;
         wb_rd_reg       <= '0;
         wb_data_reg     <= '0;
         wb_exp_reg      <= 1'b1;
         wb_exp_code_reg <= '0;
      end else if (grant_vld) begin
         ptr_reg         <= (win == PW'(CH-1)) ? '0 : win + 1'b1;
         wb_e_reg        <= 1'b0;
         wb_rd_reg       <= rd_arr[win];
         wb_data_reg     <= data_arr[win];
         wb_exp_reg      <= ch_wb_exp_[win];
         wb_exp_code_reg <= code_arr[win];
      end else begin
         wb_e_reg        <= 1'b1;
      end
   end

   assign wb_e_       = wb_e_reg;
   assign wb_rd       = wb_rd_reg;
   assign wb_data     = wb_data_reg;
   assign wb_exp_     = wb_exp_reg;
   assign wb_exp_code = wb_exp_code_reg;

endmodule
